// File: rtl/laser_scan_ctrl.sv
// laser_scan_ctrl: alternating two-circle raster search driving an external coverage evaluator
module laser_scan_ctrl #(
    parameter int MAX_ITER = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    output logic       EV_REQ,
    output logic [3:0] EV_CX,
    output logic [3:0] EV_CY,
    output logic [3:0] EV_FX,
    output logic [3:0] EV_FY,
    output logic       EV_FEN,
    input  logic       EV_ACK,
    input  logic [5:0] EV_CNT,
    output logic [3:0] C1X,
    output logic [3:0] C1Y,
    output logic [3:0] C2X,
    output logic [3:0] C2Y,
    output logic       BUSY,
    output logic       DONE
);
    localparam int IW = MAX_ITER > 1 ? $clog2(MAX_ITER) : 1;

    typedef enum logic [2:0] {IDLE, SCAN1, SCAN2, CHECK, FINISH} state_t;

    state_t        state_q;
    logic          req_q, fen_q, busy_q, done_q;
    logic [3:0]    cx_q, cy_q;
    logic [IW-1:0] iter_q;
    logic [5:0]    prev_q;
    logic [3:0]    c1x_q, c1y_q, c2x_q, c2y_q;
    logic [5:0]    c1n_q, c2n_q;
    logic [3:0]    o1x_q, o1y_q, o2x_q, o2y_q;
    logic [7:0]    pos_d;
    logic [5:0]    best_d;
    logic          last_d, better_d, gain_d, last_iter_d;

    // Next raster position, end-of-sweep, strict-improvement and loop-exit decisions
    always_comb begin
        pos_d       = {cy_q, cx_q} + 8'd1;
        last_d      = &{cy_q, cx_q};
        best_d      = state_q == SCAN2 ? c2n_q : c1n_q;
        better_d    = EV_CNT > best_d;
        gain_d      = c2n_q > prev_q;
        last_iter_d = 32'(iter_q) + 32'd1 == 32'(MAX_ITER);
    end

    // Search FSM: one idle-request cycle then a held request per candidate; outputs registered
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            fen_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
            iter_q  <= '0;
            prev_q  <= '0;
            {c1x_q, c1y_q, c1n_q} <= '0;
            {c2x_q, c2y_q, c2n_q} <= '0;
            {o1x_q, o1y_q, o2x_q, o2y_q} <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (START) begin
                    state_q <= SCAN1;
                    busy_q  <= 1'b1;
                    req_q   <= 1'b0;
                    fen_q   <= 1'b0;
                    {cy_q, cx_q} <= '0;
                    iter_q  <= '0;
                    prev_q  <= '0;
                    {c1x_q, c1y_q, c1n_q} <= '0;
                    {c2x_q, c2y_q, c2n_q} <= '0;
                end
                SCAN1, SCAN2: begin
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (EV_ACK) begin
                        req_q <= 1'b0;
                        {cy_q, cx_q} <= pos_d;
                        if (better_d && state_q == SCAN1) {c1x_q, c1y_q, c1n_q} <= {cx_q, cy_q, EV_CNT};
                        if (better_d && state_q == SCAN2) {c2x_q, c2y_q, c2n_q} <= {cx_q, cy_q, EV_CNT};
                        if (last_d && state_q == SCAN1) begin
                            state_q <= SCAN2;
                            fen_q   <= 1'b1;
                            {c2x_q, c2y_q, c2n_q} <= '0;
                        end
                        if (last_d && state_q == SCAN2) state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (gain_d && !last_iter_d) begin
                        iter_q  <= iter_q + 1'b1;
                        prev_q  <= c2n_q;
                        {c1x_q, c1y_q, c1n_q} <= '0;
                        state_q <= SCAN1;
                    end else begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    {o1x_q, o1y_q, o2x_q, o2y_q} <= {c1x_q, c1y_q, c2x_q, c2y_q};
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    fen_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign EV_REQ = req_q;
    assign EV_CX  = cx_q;
    assign EV_CY  = cy_q;
    assign EV_FX  = state_q == SCAN2 ? c1x_q : c2x_q;
    assign EV_FY  = state_q == SCAN2 ? c1y_q : c2y_q;
    assign EV_FEN = fen_q;
    assign C1X    = o1x_q;
    assign C1Y    = o1y_q;
    assign C2X    = o2x_q;
    assign C2Y    = o2y_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
endmodule

// File: tb/tb_laser_scan_ctrl.sv
// tb_laser_scan_ctrl: randomized evaluator responder plus search-level reference model
module tb_laser_scan_ctrl;
    localparam int MI = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0;
    logic       EV_REQ, EV_FEN, EV_ACK, BUSY, DONE;
    logic [3:0] EV_CX, EV_CY, EV_FX, EV_FY, C1X, C1Y, C2X, C2Y;
    logic [5:0] EV_CNT;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int g_mode = 0;
    int g_dly = 0;
    int g_noise = 0;
    int t1 [256];
    int t2 [256];

    laser_scan_ctrl #(.MAX_ITER(MI)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START),
        .EV_REQ(EV_REQ), .EV_CX(EV_CX), .EV_CY(EV_CY), .EV_FX(EV_FX), .EV_FY(EV_FY),
        .EV_FEN(EV_FEN), .EV_ACK(EV_ACK), .EV_CNT(EV_CNT),
        .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Coverage count the evaluator returns for a candidate/fixed pair; s is the scan index
    function automatic int ev(input int mode, input int s, input int cx, input int cy,
                              input int fx, input int fy, input bit fen);
        bit hc, hf;
        case (mode)
            0: return ((cx == 3 && cy == 4) || (fen && fx == 3 && fy == 4)) ? 5 : 0;
            1: begin
                hc = (cx == 2 && cy == 2) || (cx == 9 && cy == 9);
                hf = (fx == 2 && fy == 2) || (fx == 9 && fy == 9);
                return (hc || (fen && hf)) ? 7 : 0;
            end
            2: return t1[cy*16+cx] + (fen ? t2[fy*16+fx] : 0);
            default: return 2 + s;
        endcase
    endfunction

    // Whole-search reference: alternate full sweeps, keep first strict maximum, stop on no gain
    function automatic void model(input int mode, output int r1x, output int r1y,
                                  output int r2x, output int r2y, output int its);
        int prev, b, v, c1x, c1y, c2x, c2y;
        prev = 0; c1x = 0; c1y = 0; c2x = 0; c2y = 0; its = 0;
        for (int it = 0; it < MI; it++) begin
            b = 0; c1x = 0; c1y = 0;
            for (int y = 0; y < 16; y++)
                for (int x = 0; x < 16; x++) begin
                    v = ev(mode, 2*it, x, y, c2x, c2y, it > 0);
                    if (v > b) begin b = v; c1x = x; c1y = y; end
                end
            b = 0; c2x = 0; c2y = 0;
            for (int y = 0; y < 16; y++)
                for (int x = 0; x < 16; x++) begin
                    v = ev(mode, 2*it+1, x, y, c1x, c1y, 1'b1);
                    if (v > b) begin b = v; c2x = x; c2y = y; end
                end
            its = it + 1;
            if (!(b > prev) || it + 1 == MI) break;
            prev = b;
        end
        r1x = c1x; r1y = c1y; r2x = c2x; r2y = c2y;
    endfunction

    // Evaluator: random ACK delay, payload stability, raster order, FEN and gap checks
    initial begin
        bit pend, acked;
        int dly;
        logic [16:0] pay;
        EV_ACK = 1'b0; EV_CNT = '0; pend = 0; acked = 0; dly = 0; pay = '0;
        forever begin
            @(negedge CLK);
            EV_ACK = 1'b0;
            if (!RST_N) begin
                pend = 0; acked = 0;
            end else begin
                if (acked) check("req_gap", EV_REQ, 0);
                acked = 0;
                if (EV_REQ) begin
                    if (!pend) begin
                        pend = 1;
                        pay = {EV_CX, EV_CY, EV_FX, EV_FY, EV_FEN};
                        dly = $urandom_range(g_dly);
                        check("raster", {EV_CY, EV_CX}, ack_cnt % 256);
                        check("fen", EV_FEN, ack_cnt >= 256);
                    end else begin
                        check("stable", {EV_CX, EV_CY, EV_FX, EV_FY, EV_FEN}, pay);
                    end
                    if (dly == 0) begin
                        EV_ACK = 1'b1;
                        EV_CNT = 6'(ev(g_mode, ack_cnt / 256, EV_CX, EV_CY, EV_FX, EV_FY, EV_FEN));
                        pend = 0; acked = 1; ack_cnt++;
                    end else begin
                        dly--;
                    end
                end else if (g_noise != 0 && $urandom_range(1) == 1) begin
                    EV_ACK = 1'b1;
                    EV_CNT = 6'd40;
                end
            end
        end
    end

    task automatic run(input int mode, input int dly, input int noise, input int start_at,
                       output int r1x, output int r1y, output int r2x, output int r2y, output int its);
        int cyc, changed, extra;
        bit pulsed;
        logic [15:0] old;
        model(mode, r1x, r1y, r2x, r2y, its);
        g_mode = mode; g_dly = dly; g_noise = noise; ack_cnt = 0;
        changed = 0; extra = 0; pulsed = 0; cyc = 0;
        @(negedge CLK);
        old = {C1X, C1Y, C2X, C2Y};
        START = 1'b1;
        do begin
            @(negedge CLK);
            cyc++;
            START = start_at >= 0 && !pulsed && ack_cnt >= start_at;
            if (START) pulsed = 1;
            if (cyc == 1) check("busy_on", BUSY, 1);
            if (!DONE && {C1X, C1Y, C2X, C2Y} !== old) changed++;
        end while (!DONE && cyc < 30000);
        START = 1'b0;
        check("done_seen", DONE, 1);
        check("hold_outputs", changed, 0);
        check("c1x", C1X, r1x);
        check("c1y", C1Y, r1y);
        check("c2x", C2X, r2x);
        check("c2y", C2Y, r2y);
        check("acks", ack_cnt, its * 512);
        if (dly == 0) check("latency", cyc, 2 + its * 1025);
        check("busy_off", BUSY, 0);
        @(negedge CLK);
        check("done_pulse", DONE, 0);
        if (start_at >= 0) begin
            repeat (1100) begin
                @(negedge CLK);
                if (DONE) extra++;
            end
            check("no_second_done", extra, 0);
            check("no_restart_busy", BUSY, 0);
            check("no_restart_req", EV_REQ, 0);
        end
        g_noise = 0;
    endtask

    initial begin
        int a, b, c, d, n, waited;
        foreach (t1[i]) begin t1[i] = $urandom_range(20); t2[i] = $urandom_range(20); end
        repeat (3) @(negedge CLK);
        check("rst_req", EV_REQ, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_fen", EV_FEN, 0);
        check("rst_outs", {C1X, C1Y, C2X, C2Y}, 0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        check("idle_busy", BUSY, 0);

        run(0, 0, 0, -1, a, b, c, d, n);
        check("s39_c1", {C1X, C1Y}, 8'h34);
        check("s39_c2", {C2X, C2Y}, 8'h00);
        check("s39_iters", n, 2);

        run(1, 0, 0, -1, a, b, c, d, n);
        check("s40_c1", {C1X, C1Y}, 8'h22);

        run(2, 0, 0, -1, a, b, c, d, n);
        run(2, 5, 1, -1, a, b, c, d, n);

        run(3, 0, 0, -1, a, b, c, d, n);
        check("s42_iters", n, 4);

        foreach (t1[i]) begin t1[i] = $urandom_range(20); t2[i] = $urandom_range(20); end
        run(2, 0, 0, 300, a, b, c, d, n);

        g_mode = 2; g_dly = 2; ack_cnt = 0;
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        waited = 0;
        while (ack_cnt < 100 && waited < 3000) begin
            @(negedge CLK);
            waited++;
        end
        check("reach_cand100", ack_cnt >= 100, 1);
        #2 RST_N = 1'b0;
        #1;
        check("arst_req", EV_REQ, 0);
        check("arst_busy", BUSY, 0);
        check("arst_fen", EV_FEN, 0);
        check("arst_outs", {C1X, C1Y, C2X, C2Y}, 0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);
        check("post_rst_idle", {BUSY, EV_REQ, DONE}, 0);
        run(2, 0, 0, -1, a, b, c, d, n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/laser_scan_ctrl.md
LASER_SCAN_CTRL -- requirements
Module: laser_scan_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_ITER, default 4, the maximum number of SCAN1+SCAN2 iteration pairs.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port START, input, 1 bit: one-cycle request to begin a search.
REQ-005 The block SHALL have port EV_REQ, output, 1 bit: evaluation request to the coverage datapath.
REQ-006 The block SHALL have ports EV_CX and EV_CY, outputs, 4 bits each: candidate circle centre.
REQ-007 The block SHALL have ports EV_FX and EV_FY, outputs, 4 bits each: fixed (other) circle centre.
REQ-008 The block SHALL have port EV_FEN, output, 1 bit: the fixed circle counts toward coverage (union).
REQ-009 The block SHALL have port EV_ACK, input, 1 bit: evaluation complete; EV_CNT is valid.
REQ-010 The block SHALL have port EV_CNT, input, 6 bits: covered-point count, 0..40.
REQ-011 The block SHALL have ports C1X, C1Y, C2X and C2Y, outputs, 4 bits each: final centres, registered.
REQ-012 The block SHALL have port BUSY, output, 1 bit: high from the cycle after accepted START until DONE.
REQ-013 The block SHALL have port DONE, output, 1 bit: one-cycle pulse when results are valid.

Function
REQ-014 States SHALL be IDLE, SCAN1, SCAN2, CHECK and FINISH.
REQ-015 IDLE SHALL go to SCAN1 on START=1; START SHALL be ignored in every other state.
REQ-016 Each SCAN SHALL sweep the candidate over all 256 centres in raster order: y outer 0..15, x inner 0..15.
REQ-017 Handshake: EV_REQ SHALL assert with a stable payload and SHALL hold until the cycle EV_ACK=1 is sampled.
REQ-018 EV_REQ SHALL be low for exactly one cycle between transactions, giving a minimum of 2 cycles per candidate.
REQ-019 EV_ACK received while EV_REQ=0 SHALL be ignored.
REQ-020 EV_ACK in the first cycle of EV_REQ SHALL be legal.
REQ-021 SCAN1 SHALL drive the candidate as C1 and fixed={C2 best}.
REQ-022 In SCAN1, EV_FEN SHALL be 0 in iteration 0 and 1 afterwards.
REQ-023 SCAN2 SHALL drive the candidate as C2 with fixed={C1 best} and EV_FEN=1.
REQ-024 Best update SHALL require a strictly greater EV_CNT than the current best in that scan; ties SHALL keep the earlier raster position.
REQ-025 Each scan's best SHALL start at count 0 and position (0,0).
REQ-026 C1 best SHALL update only in SCAN1, and C2 best only in SCAN2; both SHALL be held between scans.
REQ-027 After the last candidate (15,15) is acknowledged, SCAN1 SHALL go to SCAN2 and SCAN2 SHALL go to CHECK.
REQ-028 CHECK (1 cycle) SHALL compare the SCAN2 best count with the previous iteration's SCAN2 best count.
REQ-029 CHECK SHALL go to FINISH if the count is not greater or iteration+1==MAX_ITER; otherwise it SHALL increment the iteration and go to SCAN1.
REQ-030 The previous-iteration count SHALL reset to 0 at START.
REQ-031 FINISH (1 cycle) SHALL load C1X/C1Y/C2X/C2Y from the bests, pulse DONE=1 and return to IDLE.
REQ-032 C1X/C1Y/C2X/C2Y SHALL hold until the next FINISH; the outputs SHALL NOT change during a search.
REQ-033 The iteration counter SHALL be wide enough for MAX_ITER; with MAX_ITER=1 the search SHALL be exactly one SCAN1+SCAN2.
REQ-034 EV_CNT SHALL be compared as unsigned 6 bits, with no saturation.
REQ-035 Latency with immediate ACK SHALL be 512 cycles per scan; total = 1 + iterations×(1024+1) + 1 cycles from START to DONE.

Reset
REQ-036 RST_N=0 SHALL force IDLE immediately, with EV_REQ=0, EV_FEN=0, BUSY=0, DONE=0, all centre outputs 0, and all counters and bests 0.
REQ-037 Reset mid-search SHALL abandon the transaction without any ACK being required.
REQ-038 After reset is released, the block SHALL wait for a new START.

Verification
REQ-039 Scenario: evaluator returns 5 for centre (3,4) and 0 elsewhere; ACK immediate -> C1=(3,4), C2=(0,0), DONE after 2 iterations (second gives no gain).
REQ-040 Scenario: evaluator returns 7 at (2,2) and at (9,9) in SCAN1 -> C1=(2,2) (tie keeps earlier raster position).
REQ-041 Scenario: random ACK delay 0..5 cycles -> EV_REQ payload stable while waiting; exactly 256 ACKed requests per scan; results identical to the immediate-ACK run.
REQ-042 Scenario: SCAN2 count strictly increases every iteration with MAX_ITER=4 -> exactly 4 iteration pairs, then DONE.
REQ-043 Scenario: START pulsed during SCAN2 -> ignored, with no restart and no second DONE.
REQ-044 Scenario: RST_N low at candidate 100 of SCAN1 -> EV_REQ low and outputs 0 asynchronously; a fresh START gives a correct full run.
